// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/response bundle for the bit-serial add/subtract sequencer.
//   master: drives start_i, mode_i, a_i, b_i; observes busy_o, done_o, result_o, cout_o, ovf_o
//   slave : the sequencer side of the same signals
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             mode_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             cout_o;
    logic             ovf_o;

    modport master (
        output start_i, mode_i, a_i, b_i,
        input  busy_o, done_o, result_o, cout_o, ovf_o
    );

    modport slave (
        input  start_i, mode_i, a_i, b_i,
        output busy_o, done_o, result_o, cout_o, ovf_o
    );
endinterface

// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: bit-serial add/subtract sequencer, operands streamed LSB-first through one full adder.
//   clk_i    : system clock, rising edge
//   reset_ni : synchronous active-low reset
//   bus      : serial_addsub_if slave (start/mode/a/b in; busy/done/result/cout/ovf out)
module serial_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    serial_addsub_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             sum_bit, maj;

    assign sum_bit = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign maj     = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                // Subtract is a + ~b + 1: invert b and seed the carry with the mode bit.
                state_d = SHIFT;
                cnt_d   = '0;
                carry_d = bus.mode_i;
                sa_d    = bus.a_i;
                sb_d    = bus.mode_i ? ~bus.b_i : bus.b_i;
                res_d   = '0;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
            end
            SHIFT: begin
                carry_d = maj;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB here; maj is the carry out of it.
                    state_d = DONE;
                    cnt_d   = '0;
                    cout_d  = maj;
                    ovf_d   = carry_q ^ maj;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy_o   = state_q != IDLE;
    assign bus.done_o   = state_q == DONE;
    assign bus.result_o = res_q;
    assign bus.cout_o   = cout_q;
    assign bus.ovf_o    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_seq.sv
// tb_serial_addsub_seq: directed and randomised scoreboard bench for serial_addsub_seq (WIDTH=8).
module tb_serial_addsub_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_done = -1;
    exp_t sb[$];

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", int'(bus.result_o), int'(e.r));
                check("cout", int'(bus.cout_o), int'(e.c));
                check("ovf", int'(bus.ovf_o), int'(e.o));
            end
            if (last_done >= 0) begin
                n_chk++;
                if (cyc - last_done < W + 2) begin
                    n_fail++;
                    $display("FAIL done_spacing: got %0d expected >= %0d", cyc - last_done, W + 2);
                end
            end
            last_done = cyc;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input exp_t e);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.mode_i  = m;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = ~a;
        bus.b_i     = a ^ 8'h5C;
        bus.mode_i  = ~m;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] r, input logic c, input logic o);
        int n;
        int nb;
        issue(a, b, m, '{r: r, c: c, o: o});
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy_o) nb++;
        end while (!bus.done_o && n < 30);
        check("latency", n, W + 1);
        check("busy_cycles", nb, W + 1);
        @(negedge clk);
        check("idle_busy", int'(bus.busy_o), 0);
        check("hold_result", int'(bus.result_o), int'(r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ra, rb, bb, rr;
        logic rm, rc, ro;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_result", int'(bus.result_o), 0);
        check("rst_cout", int'(bus.cout_o), 0);
        check("rst_ovf", int'(bus.ovf_o), 0);

        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        do_op(8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        do_op(8'h3C, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        issue(8'h01, 8'h02, 1'b0, '{r: 8'h03, c: 1'b0, o: 1'b0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.start_i = (n == 3);
            bus.a_i     = 8'hFF;
            bus.b_i     = 8'hFF;
        end while (!bus.done_o && n < 30);
        check("busy_latency", n, W + 1);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        do_op(8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

        issue(8'h35, 8'h4A, 1'b0, '{r: 8'h00, c: 1'b0, o: 1'b0});
        void'(sb.pop_back());
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(bus.busy_o), 0);
        check("mid_rst_done", int'(bus.done_o), 0);
        check("mid_rst_result", int'(bus.result_o), 0);
        check("mid_rst_cout", int'(bus.cout_o), 0);
        check("mid_rst_ovf", int'(bus.ovf_o), 0);
        repeat (12) @(negedge clk);
        check("mid_rst_idle", int'(bus.busy_o), 0);
        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            bb = rm ? ~rb : rb;
            {rc, rr} = {1'b0, ra} + {1'b0, bb} + {8'h00, rm};
            ro = (ra[W-1] == bb[W-1]) && (rr[W-1] != ra[W-1]);
            do_op(ra, rb, rm, rr, rc, ro);
        end

        repeat (3) @(negedge clk);
        check("pending_ops", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
